// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared widths, loader state enum and address helper
//
// Purpose: common definitions for the program loader slice.
// Contents:
//   HALF_WORD      width of one Thumb half-word (instruction_o)
//   WORD           width of a byte address (instruction_addr_o)
//   loader_state_t loader FSM states
//   half_word_addr byte address of half-word idx given base and stride
package program_loader_pkg;

    localparam int HALF_WORD = 16;
    localparam int WORD      = 32;

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA_LO,
        DATA_HI,
        CHK,
        DONE,
        ERROR
    } loader_state_t;

    // Unsigned WORD-wide arithmetic; callers keep idx below the memory
    // capacity so the result never wraps.
    function automatic logic [WORD-1:0] half_word_addr(
        input logic [WORD-1:0] base,
        input logic [WORD-1:0] stride,
        input logic [15:0]     idx
    );
        return base + WORD'(idx) * stride;
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - byte stream, program memory write and CPU control bundle
//
// Purpose: groups the loader's handshake and bus signals.
// Signals:
//   rx_valid_i, rx_byte_i, rx_ready_o     incoming byte stream handshake
//   reload_i                              restart request (honoured only in DONE)
//   program_mem_write_en_o, instruction_o,
//   instruction_addr_o                    instruction memory write port
//   cpu_reset_o, load_done_o, error_o     CPU reset and load status
// Modports:
//   master  harness / UART side driving bytes and observing the loader
//   slave   the loader itself
interface program_loader_if;
    import program_loader_pkg::*;

    logic                 rx_valid_i;
    logic [7:0]           rx_byte_i;
    logic                 rx_ready_o;
    logic                 reload_i;
    logic                 program_mem_write_en_o;
    logic [HALF_WORD-1:0] instruction_o;
    logic [WORD-1:0]      instruction_addr_o;
    logic                 cpu_reset_o;
    logic                 load_done_o;
    logic                 error_o;

    modport master (
        output rx_valid_i, rx_byte_i, reload_i,
        input  rx_ready_o, program_mem_write_en_o, instruction_o,
               instruction_addr_o, cpu_reset_o, load_done_o, error_o
    );

    modport slave (
        input  rx_valid_i, rx_byte_i, reload_i,
        output rx_ready_o, program_mem_write_en_o, instruction_o,
               instruction_addr_o, cpu_reset_o, load_done_o, error_o
    );

endinterface

// File: rtl/loader_checksum.sv
// rtl/loader_checksum.sv - 8-bit XOR accumulator with clear and enable
//
// Purpose: running XOR of payload bytes for the loader frame check.
// Ports:
//   clk_i     clock
//   reset_i   synchronous active-high reset, clears the sum
//   clear_i   synchronous clear (start of a new frame)
//   enable_i  fold byte_i into the sum this cycle
//   byte_i    payload byte
//   sum_o     registered running XOR
module loader_checksum (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       clear_i,
    input  logic       enable_i,
    input  logic [7:0] byte_i,
    output logic [7:0] sum_o
);

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            sum_o <= 8'h00;
        end else if (enable_i) begin
            sum_o <= sum_o ^ byte_i;
        end
    end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot loader filling CPU instruction memory from a byte stream
//
// Purpose: parses LEN_LO, LEN_HI, N x {lo, hi}, CHK frames, writes each
// half-word to program memory and releases the CPU from reset after a
// clean load. A bad checksum or oversize header parks in ERROR until reset.
// Parameters:
//   MAX_HALF_WORDS  instruction memory capacity in half-words
//   BASE_ADDR       byte address of the first half-word
//   ADDR_STRIDE     byte-address increment per half-word
// Ports:
//   clk_i    clock
//   reset_i  synchronous active-high reset
//   bus      program_loader_if slave (stream, memory write, CPU control)
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned MAX_HALF_WORDS = 1024,
    parameter int unsigned BASE_ADDR      = 0,
    parameter int unsigned ADDR_STRIDE    = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    program_loader_if.slave  bus
);

    loader_state_t        state;
    logic [15:0]          len;
    logic [15:0]          count;
    logic [7:0]           lo_byte;
    logic                 rx_ready_q;
    logic                 write_en_q;
    logic [HALF_WORD-1:0] instr_q;
    logic [WORD-1:0]      addr_q;
    logic                 cpu_reset_q;
    logic                 done_q;
    logic                 error_q;
    logic [7:0]           checksum;

    logic                 accept;
    logic [15:0]          new_len;
    logic                 oversize;
    logic [15:0]          count_next;
    logic                 payload_byte;
    logic                 frame_clear;

    assign accept       = bus.rx_valid_i & rx_ready_q;
    assign new_len      = {bus.rx_byte_i, len[7:0]};
    assign oversize     = 32'(new_len) > WORD'(MAX_HALF_WORDS);
    assign count_next   = count + 16'd1;
    assign payload_byte = accept && (state == DATA_LO || state == DATA_HI);
    assign frame_clear  = (state == DONE) && bus.reload_i;

    // The sum is registered, so by the time a CHK byte can be accepted
    // (at least one cycle after the last hi byte) it covers every payload byte.
    loader_checksum u_checksum (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .clear_i  (frame_clear),
        .enable_i (payload_byte),
        .byte_i   (bus.rx_byte_i),
        .sum_o    (checksum)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= LEN_LO;
            len         <= 16'd0;
            count       <= 16'd0;
            lo_byte     <= 8'h00;
            rx_ready_q  <= 1'b1;
            write_en_q  <= 1'b0;
            instr_q     <= '0;
            addr_q      <= WORD'(BASE_ADDR);
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse following each hi byte.
            write_en_q <= 1'b0;
            case (state)
                LEN_LO: begin
                    if (accept) begin
                        len[7:0] <= bus.rx_byte_i;
                        state    <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        len[15:8] <= bus.rx_byte_i;
                        if (new_len == 16'd0) begin
                            state <= CHK;
                        end else if (oversize) begin
                            state      <= ERROR;
                            rx_ready_q <= 1'b0;
                            error_q    <= 1'b1;
                        end else begin
                            state <= DATA_LO;
                        end
                    end
                end
                DATA_LO: begin
                    if (accept) begin
                        lo_byte <= bus.rx_byte_i;
                        state   <= DATA_HI;
                    end
                end
                DATA_HI: begin
                    if (accept) begin
                        instr_q    <= {bus.rx_byte_i, lo_byte};
                        write_en_q <= 1'b1;
                        addr_q     <= half_word_addr(WORD'(BASE_ADDR),
                                                     WORD'(ADDR_STRIDE), count);
                        count      <= count_next;
                        state      <= (count_next == len) ? CHK : DATA_LO;
                    end
                end
                CHK: begin
                    if (accept) begin
                        rx_ready_q <= 1'b0;
                        if (bus.rx_byte_i == checksum) begin
                            state       <= DONE;
                            cpu_reset_q <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            state   <= ERROR;
                            error_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.reload_i) begin
                        state       <= LEN_LO;
                        len         <= 16'd0;
                        count       <= 16'd0;
                        rx_ready_q  <= 1'b1;
                        cpu_reset_q <= 1'b1;
                        done_q      <= 1'b0;
                    end
                end
                ERROR: begin
                    // Sticky until reset_i; reload_i deliberately ignored.
                    state       <= ERROR;
                    cpu_reset_q <= 1'b1;
                end
                default: begin
                    state <= ERROR;
                end
            endcase
        end
    end

    assign bus.rx_ready_o             = rx_ready_q;
    assign bus.program_mem_write_en_o = write_en_q;
    assign bus.instruction_o          = instr_q;
    assign bus.instruction_addr_o     = addr_q;
    assign bus.cpu_reset_o            = cpu_reset_q;
    assign bus.load_done_o            = done_q;
    assign bus.error_o                = error_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

    logic clk = 1'b0;
    logic reset = 1'b1;

    program_loader_if bus ();

    program_loader u_dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [15:0] wr_data[$];
    logic [31:0] wr_addr[$];

    always @(negedge clk) begin
        if (bus.program_mem_write_en_o) begin
            wr_data.push_back(bus.instruction_o);
            wr_addr.push_back(bus.instruction_addr_o);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.rx_valid_i = 1'b0;
        bus.reload_i   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        wr_data.delete();
        wr_addr.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        bus.rx_valid_i = 1'b1;
        bus.rx_byte_i  = b;
        while (!bus.rx_ready_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10) check_eq("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.rx_valid_i = 1'b0;
        bus.rx_byte_i  = 8'hEE;
    endtask

    task automatic send_frame(input logic [7:0] bytes[], input int max_gap);
        foreach (bytes[i]) begin
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(posedge clk);
            send_byte(bytes[i]);
        end
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    task automatic check_good_writes(input string tag);
        check_eq({tag, "_nwr"}, 32'(wr_data.size()), 32'd2);
        if (wr_data.size() == 2) begin
            check_eq({tag, "_d0"}, 32'(wr_data[0]), 32'h1234);
            check_eq({tag, "_a0"}, wr_addr[0], 32'h0);
            check_eq({tag, "_d1"}, 32'(wr_data[1]), 32'h5678);
            check_eq({tag, "_a1"}, wr_addr[1], 32'h2);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_ready"}, 32'(bus.rx_ready_o), 32'd1);
        check_eq({tag, "_we"},    32'(bus.program_mem_write_en_o), 32'd0);
        check_eq({tag, "_instr"}, 32'(bus.instruction_o), 32'h0);
        check_eq({tag, "_addr"},  bus.instruction_addr_o, 32'h0);
        check_eq({tag, "_cpurst"},32'(bus.cpu_reset_o), 32'd1);
        check_eq({tag, "_done"},  32'(bus.load_done_o), 32'd0);
        check_eq({tag, "_err"},   32'(bus.error_o), 32'd0);
    endtask

    // 0x34^0x12^0x78^0x56 = 0x08
    logic [7:0] good_hdr_data[] = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
    logic [7:0] good_frame[]    = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h08};
    logic [7:0] badchk_frame[]  = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h09};
    logic [7:0] oversize_hdr[]  = '{8'h01, 8'h04};
    logic [7:0] zero_frame[]    = '{8'h00, 8'h00, 8'h00};
    logic [7:0] zero_bad[]      = '{8'h00, 8'h00, 8'h01};
    logic [7:0] first_half[]    = '{8'h02, 8'h00, 8'h34, 8'h12};
    logic [7:0] reload_frame[]  = '{8'h01, 8'h00, 8'hAB, 8'hCD, 8'h66};

    initial begin
        bus.rx_valid_i = 1'b0;
        bus.rx_byte_i  = 8'h00;
        bus.reload_i   = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        check_reset_values("rst");

        // Good load, back to back, with release timing around the CHK byte.
        send_frame(good_hdr_data, 0);
        check_eq("good_cpurst_pre", 32'(bus.cpu_reset_o), 32'd1);
        send_byte(8'h08);
        check_eq("good_cpurst_post", 32'(bus.cpu_reset_o), 32'd0);
        check_eq("good_done", 32'(bus.load_done_o), 32'd1);
        settle();
        check_good_writes("good");
        check_eq("good_ready", 32'(bus.rx_ready_o), 32'd0);
        check_eq("good_err", 32'(bus.error_o), 32'd0);
        check_eq("good_addr_hold", bus.instruction_addr_o, 32'h2);

        // Reload from DONE with a one-word frame.
        @(negedge clk);
        bus.reload_i = 1'b1;
        @(posedge clk);
        #1;
        bus.reload_i = 1'b0;
        check_eq("rld_cpurst", 32'(bus.cpu_reset_o), 32'd1);
        check_eq("rld_done", 32'(bus.load_done_o), 32'd0);
        check_eq("rld_ready", 32'(bus.rx_ready_o), 32'd1);
        wr_data.delete();
        wr_addr.delete();
        send_frame(reload_frame, 0);
        settle();
        check_eq("rld_nwr", 32'(wr_data.size()), 32'd1);
        if (wr_data.size() == 1) begin
            check_eq("rld_d0", 32'(wr_data[0]), 32'hCDAB);
            check_eq("rld_a0", wr_addr[0], 32'h0);
        end
        check_eq("rld_done2", 32'(bus.load_done_o), 32'd1);
        check_eq("rld_cpurst2", 32'(bus.cpu_reset_o), 32'd0);

        // Bad checksum: writes happen, then sticky ERROR.
        do_reset();
        send_frame(badchk_frame, 0);
        settle();
        check_good_writes("badchk");
        check_eq("badchk_err", 32'(bus.error_o), 32'd1);
        check_eq("badchk_cpurst", 32'(bus.cpu_reset_o), 32'd1);
        check_eq("badchk_ready", 32'(bus.rx_ready_o), 32'd0);
        @(negedge clk);
        bus.reload_i = 1'b1;
        @(negedge clk);
        bus.reload_i = 1'b0;
        settle();
        check_eq("badchk_rld_err", 32'(bus.error_o), 32'd1);
        check_eq("badchk_rld_ready", 32'(bus.rx_ready_o), 32'd0);
        check_eq("badchk_rld_done", 32'(bus.load_done_o), 32'd0);

        // Oversize header: ERROR right after LEN_HI, no strobe.
        do_reset();
        send_frame(oversize_hdr, 0);
        check_eq("over_err", 32'(bus.error_o), 32'd1);
        check_eq("over_ready", 32'(bus.rx_ready_o), 32'd0);
        settle();
        check_eq("over_nwr", 32'(wr_data.size()), 32'd0);

        // Zero length, good and bad CHK.
        do_reset();
        send_frame(zero_frame, 0);
        settle();
        check_eq("zero_done", 32'(bus.load_done_o), 32'd1);
        check_eq("zero_nwr", 32'(wr_data.size()), 32'd0);
        do_reset();
        send_frame(zero_bad, 0);
        settle();
        check_eq("zerobad_err", 32'(bus.error_o), 32'd1);
        check_eq("zerobad_done", 32'(bus.load_done_o), 32'd0);

        // Stalled stream with random gaps.
        do_reset();
        send_frame(good_frame, 5);
        settle();
        check_good_writes("gap");
        check_eq("gap_done", 32'(bus.load_done_o), 32'd1);

        // Mid-load reset after the first half-word, then a fresh load.
        do_reset();
        send_frame(first_half, 0);
        check_eq("mid_we", 32'(bus.program_mem_write_en_o), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("mid");
        @(negedge clk);
        reset = 1'b0;
        wr_data.delete();
        wr_addr.delete();
        send_frame(good_frame, 0);
        settle();
        check_good_writes("mid2");
        check_eq("mid2_done", 32'(bus.load_done_o), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
